// File: rtl/tremolo_pkg.sv
// rtl/tremolo_pkg.sv - shared constants and state encoding for the tremolo stage
package tremolo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAIN = 2'd1,
        ST_MULT = 2'd2,
        ST_OUT  = 2'd3
    } tremolo_state_e;

    localparam int LFO_MAX    = 512;
    localparam int DEPTH_FULL = 256;
    localparam int GAIN_W     = 10;
    localparam int GAIN_SHIFT = 9;
    // Width that holds a clamped depth (0..DEPTH_FULL).
    localparam int DEPTH_C_W  = 9;

endpackage

// File: rtl/tremolo_modulator_if.sv
// rtl/tremolo_modulator_if.sv - control, sample-in and sample-out signals of the tremolo stage
interface tremolo_modulator_if #(
    parameter int DATA_W  = 16,
    parameter int LFO_W   = 32,
    parameter int DEPTH_W = 9
);
    logic                      enable;
    logic [DEPTH_W-1:0]        depth;
    logic [LFO_W-1:0]          lfo;
    logic signed [DATA_W-1:0]  in_sample;
    logic                      in_valid;
    logic                      in_ready;
    logic signed [DATA_W-1:0]  out_sample;
    logic                      out_valid;
    logic                      out_ready;

    // Upstream source / downstream sink side (testbench or surrounding fabric).
    modport master (
        output enable, depth, lfo, in_sample, in_valid, out_ready,
        input  in_ready, out_sample, out_valid
    );

    // The tremolo stage itself.
    modport slave (
        input  enable, depth, lfo, in_sample, in_valid, out_ready,
        output in_ready, out_sample, out_valid
    );
endinterface

// File: rtl/tremolo_modulator_gain_calc.sv
// rtl/tremolo_modulator_gain_calc.sv - combinational clamp and depth-weighted gain equation
module tremolo_gain_calc
    import tremolo_pkg::*;
#(
    parameter int LFO_W   = 32,
    parameter int DEPTH_W = 9
) (
    input  logic [LFO_W-1:0]   lfo_i,
    input  logic [DEPTH_W-1:0] depth_i,
    input  logic               enable_i,
    output logic [GAIN_W-1:0]  gain_o
);

    localparam logic [GAIN_W-1:0]    GAIN_FULL = GAIN_W'(LFO_MAX);
    localparam int                   PROD_W    = DEPTH_C_W + GAIN_W;

    logic [GAIN_W-1:0]    lfo_c;
    logic [DEPTH_C_W-1:0] depth_c;
    logic [GAIN_W-1:0]    span;
    logic [PROD_W-1:0]    dip;

    // Clamp both controls, then gain = 512 - depth * (512 - lfo) / 256; bypass forces unity.
    always_comb begin
        lfo_c   = (lfo_i >= LFO_W'(LFO_MAX)) ? GAIN_FULL : lfo_i[GAIN_W-1:0];
        depth_c = (depth_i > DEPTH_W'(DEPTH_FULL)) ? DEPTH_C_W'(DEPTH_FULL)
                                                    : DEPTH_C_W'(depth_i);
        span    = GAIN_FULL - lfo_c;
        dip     = PROD_W'(depth_c) * PROD_W'(span);
        // dip >> 8 never exceeds 512, so the subtraction cannot wrap.
        gain_o  = enable_i ? (GAIN_FULL - GAIN_W'(dip >> 8)) : GAIN_FULL;
    end

endmodule

// File: rtl/tremolo_modulator.sv
// rtl/tremolo_modulator.sv - tremolo amplitude modulator: capture, gain, multiply, hand off
module tremolo_modulator
    import tremolo_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int LFO_W   = 32,
    parameter int DEPTH_W = 9
) (
    input  logic                CLK,
    input  logic                RST,
    tremolo_modulator_if.slave  bus
);

    localparam logic [1:0] IDLE = 2'(ST_IDLE);
    localparam logic [1:0] GAIN = 2'(ST_GAIN);
    localparam logic [1:0] MULT = 2'(ST_MULT);
    localparam logic [1:0] OUT  = 2'(ST_OUT);

    localparam int PROD_W = DATA_W + GAIN_W + 1;

    logic [1:0]               state_q, state_d;
    logic signed [DATA_W-1:0] sample_q, sample_d;
    logic [GAIN_W-1:0]        lfo_q, lfo_d;
    logic [DEPTH_W-1:0]       depth_q, depth_d;
    logic                     en_q, en_d;
    logic [GAIN_W-1:0]        gain_q, gain_d;
    logic signed [DATA_W-1:0] out_sample_q, out_sample_d;
    logic                     out_valid_q, out_valid_d;

    logic [GAIN_W-1:0]        gain_calc;
    logic signed [PROD_W-1:0] product;
    logic                     accept;

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = out_valid_q;
    assign bus.out_sample = out_sample_q;
    assign accept         = bus.in_valid && (state_q == IDLE);

    // The gain is computed from the captured (already clamped) controls, so later
    // LFO or depth changes cannot disturb the sample in flight.
    tremolo_gain_calc #(
        .LFO_W   (GAIN_W),
        .DEPTH_W (DEPTH_W)
    ) u_gain_calc (
        .lfo_i    (lfo_q),
        .depth_i  (depth_q),
        .enable_i (en_q),
        .gain_o   (gain_calc)
    );

    // Gain is zero-extended to a positive signed operand before the multiply.
    always_comb begin
        product = PROD_W'(sample_q) * PROD_W'($signed({1'b0, gain_q}));
    end

    // Next-state logic for the FSM and all capture/pipeline registers.
    always_comb begin
        state_d      = state_q;
        sample_d     = sample_q;
        lfo_d        = lfo_q;
        depth_d      = depth_q;
        en_d         = en_q;
        gain_d       = gain_q;
        out_sample_d = out_sample_q;
        out_valid_d  = out_valid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sample_d = bus.in_sample;
                    lfo_d    = (bus.lfo >= LFO_W'(LFO_MAX)) ? GAIN_W'(LFO_MAX)
                                                            : bus.lfo[GAIN_W-1:0];
                    depth_d  = (bus.depth > DEPTH_W'(DEPTH_FULL)) ? DEPTH_W'(DEPTH_FULL)
                                                                  : bus.depth;
                    en_d     = bus.enable;
                    state_d  = GAIN;
                end
            end
            GAIN: begin
                gain_d  = gain_calc;
                state_d = MULT;
            end
            MULT: begin
                // Arithmetic shift floors toward negative infinity; gain <= 512
                // guarantees the result fits DATA_W without saturation.
                out_sample_d = DATA_W'(product >>> GAIN_SHIFT);
                out_valid_d  = 1'b1;
                state_d      = OUT;
            end
            OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and data registers; reset drops any sample in flight immediately.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            sample_q     <= '0;
            lfo_q        <= '0;
            depth_q      <= '0;
            en_q         <= 1'b0;
            gain_q       <= '0;
            out_sample_q <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_q     <= sample_d;
            lfo_q        <= lfo_d;
            depth_q      <= depth_d;
            en_q         <= en_d;
            gain_q       <= gain_d;
            out_sample_q <= out_sample_d;
            out_valid_q  <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_tremolo_modulator.sv
// tb/tb_tremolo_modulator.sv - directed self-checking bench for tremolo_modulator
module tb_tremolo_modulator;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    tremolo_modulator_if #(.DATA_W(16), .LFO_W(32), .DEPTH_W(9)) bus ();

    tremolo_modulator #(.DATA_W(16), .LFO_W(32), .DEPTH_W(9)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run_sample(input string tag, input int s, input int l, input int l_after,
                              input int d, input bit en, input int exp, input int stall);
        int lat;
        int waited;
        waited = 0;
        while (!bus.in_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check_eq({tag, "_in_ready"}, int'(bus.in_ready), 1);
        bus.in_sample = s[15:0];
        bus.lfo       = l;
        bus.depth     = d[8:0];
        bus.enable    = en;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.lfo      = l_after;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, "_latency"}, lat, 2);
        check_eq({tag, "_value"}, int'(bus.out_sample), exp);
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            check_eq({tag, "_hold_valid"}, int'(bus.out_valid), 1);
            check_eq({tag, "_hold_value"}, int'(bus.out_sample), exp);
            check_eq({tag, "_hold_in_ready"}, int'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check_eq({tag, "_done_valid"}, int'(bus.out_valid), 0);
        check_eq({tag, "_done_in_ready"}, int'(bus.in_ready), 1);
    endtask

    initial begin
        int samples [3];
        int idx;
        int hits;
        int last_c;
        bit prev_ready;
        int lat;

        n_checks = 0;
        n_errors = 0;
        rst           = 1'b1;
        bus.enable    = 1'b1;
        bus.depth     = '0;
        bus.lfo       = '0;
        bus.in_sample = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_in_ready", int'(bus.in_ready), 1);
        check_eq("reset_out_valid", int'(bus.out_valid), 0);
        check_eq("reset_out_sample", int'(bus.out_sample), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // tag, sample, lfo, lfo after accept, depth, enable, expected, stall cycles
        run_sample("pass_depth0",  1000,   0,   0,   0, 1'b1,  1000, 0);
        run_sample("pass_disable", 1000,   0,   0, 256, 1'b0,  1000, 0);
        run_sample("trough",       1000,   0,   0, 256, 1'b1,     0, 0);
        run_sample("peak",         1000, 512, 512, 256, 1'b1,  1000, 0);
        run_sample("half_pos",     1000, 256, 256, 256, 1'b1,   500, 0);
        run_sample("half_neg",    -1001, 256, 256, 256, 1'b1,  -501, 0);
        run_sample("half_min",   -32768, 256, 256, 256, 1'b1, -16384, 0);
        run_sample("depth128",     1000,   0,   0, 128, 1'b1,   500, 0);
        run_sample("lfo_clamp",    1234, 600, 600, 256, 1'b1,  1234, 0);
        run_sample("depth_clamp",  1000,   0,   0, 300, 1'b1,     0, 0);
        run_sample("stall5",       -777, 256, 256, 256, 1'b1,  -389, 5);
        run_sample("lfo_late",     1000, 256,   0, 256, 1'b1,   500, 0);

        // Back-to-back with the sink always ready: one output every 4 cycles.
        samples[0] = 100;
        samples[1] = -200;
        samples[2] = 300;
        bus.enable    = 1'b0;
        bus.depth     = 9'd256;
        bus.lfo       = 32'd0;
        bus.out_ready = 1'b1;
        idx  = 0;
        hits = 0;
        last_c = 0;
        bus.in_sample = samples[0][15:0];
        bus.in_valid  = 1'b1;
        for (int c = 0; c < 20; c++) begin
            prev_ready = bus.in_ready;
            @(posedge clk); #1;
            if (prev_ready && bus.in_valid) begin
                idx++;
                if (idx < 3) bus.in_sample = samples[idx][15:0];
                else         bus.in_valid  = 1'b0;
            end
            if (bus.out_valid) begin
                if (hits < 3) check_eq("b2b_value", int'(bus.out_sample), samples[hits]);
                if (hits > 0) check_eq("b2b_spacing", c - last_c, 4);
                last_c = c;
                hits++;
            end
        end
        check_eq("b2b_count", hits, 3);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;

        // Reset while the result sits in OUT.
        bus.in_sample = 16'sd1000;
        bus.enable    = 1'b0;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("rst_pre_valid", int'(bus.out_valid), 1);
        check_eq("rst_pre_value", int'(bus.out_sample), 1000);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_out_valid", int'(bus.out_valid), 0);
        check_eq("rst_out_sample", int'(bus.out_sample), 0);
        check_eq("rst_in_ready", int'(bus.in_ready), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_after_valid", int'(bus.out_valid), 0);
        run_sample("after_rst",    1000, 256, 256, 256, 1'b1,   500, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
